// File: rtl/hall_emulator_if.sv
// Control/status bundle of the Hall sensor emulator.
interface hall_emulator_if;
    logic        en;
    logic        direct;
    logic [31:0] period;
    logic        load;
    logic [2:0]  load_sector;
    logic [2:0]  hall_o;
    logic [2:0]  sector_o;
    logic [31:0] angle_o;
    logic        step_o;
    logic        busy_o;

    modport master (
        output en, direct, period, load, load_sector,
        input  hall_o, sector_o, angle_o, step_o, busy_o
    );

    modport slave (
        input  en, direct, period, load, load_sector,
        output hall_o, sector_o, angle_o, step_o, busy_o
    );
endinterface

// File: rtl/hall_emulator.sv
// Steps through six Hall sectors at a programmable rate; hall/sector/angle
// are registered together so they always describe the same sector.
module hall_emulator #(
    parameter logic [3:0]  HALL_N0      = 4'h4,
    parameter logic [3:0]  HALL_N1      = 4'h5,
    parameter logic [3:0]  HALL_N2      = 4'h1,
    parameter logic [3:0]  HALL_N3      = 4'h3,
    parameter logic [3:0]  HALL_N4      = 4'h2,
    parameter logic [3:0]  HALL_N5      = 4'h6,
    parameter logic [31:0] SECTOR_ANGLE = 32'd600000
) (
    input  logic            clk,
    input  logic            rst_n,
    hall_emulator_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt, period_r;
    logic [2:0]  sector, sector_step, sector_d;
    logic        start, tc, step;

    function automatic logic [2:0] hall_of(input logic [2:0] s);
        case (s)
            3'd1:    hall_of = HALL_N1[2:0];
            3'd2:    hall_of = HALL_N2[2:0];
            3'd3:    hall_of = HALL_N3[2:0];
            3'd4:    hall_of = HALL_N4[2:0];
            3'd5:    hall_of = HALL_N5[2:0];
            default: hall_of = HALL_N0[2:0];
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        tc          = 1'b0;
        step        = 1'b0;
        sector_step = sector;
        sector_d    = sector;
        case (state)
            IDLE:    if (bus.en && bus.period != 32'd0) state_nxt = RUN;
            RUN:     if (!bus.en || bus.period == 32'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A load strobe owns the cycle: no transition, no step.
        if (bus.load) state_nxt = state;
        start = (state == IDLE) && (state_nxt == RUN);
        tc    = (state == RUN) && (cnt == period_r - 32'd1);
        step  = tc && (state_nxt == RUN) && !bus.load;
        if (bus.direct) sector_step = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
        else            sector_step = (sector == 3'd0) ? 3'd5 : sector - 3'd1;
        if (bus.load) begin
            if (bus.load_sector <= 3'd5) sector_d = bus.load_sector;
        end else if (step) begin
            sector_d = sector_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 32'd0;
            period_r   <= 32'd0;
            sector     <= 3'd0;
            bus.hall_o <= HALL_N0[2:0];
            bus.angle_o <= 32'd0;
            bus.step_o <= 1'b0;
        end else begin
            bus.step_o  <= step;
            sector      <= sector_d;
            bus.hall_o  <= hall_of(sector_d);
            bus.angle_o <= {29'd0, sector_d} * SECTOR_ANGLE;
            if (bus.load) begin
                cnt <= 32'd0;
            end else if (start) begin
                cnt      <= 32'd0;
                period_r <= bus.period;
            end else if (state == RUN && state_nxt == RUN) begin
                // Step length is only re-sampled at the boundary.
                if (tc) begin
                    cnt      <= 32'd0;
                    period_r <= bus.period;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end

    assign bus.sector_o = sector;
    assign bus.busy_o   = (state == RUN);
endmodule
